pipe_trace_buffer: RTL
======================

# pipe_trace_buffer

Trace capture unit that observes the CPU's fetch stream and records {PC, instruction} pairs around a programmable trigger PC. It is the read-side counterpart to the stimulus bench: the bench drives the CPU, and this block captures what the CPU actually executed. After a run, the bench or a debug port drains the record through a valid/ready handshake. It sits beside the CPU top level, tapping the fetch-stage PC and instruction.

## Interface
- DEPTH, 16: FIFO entries, power of two, ≥ 4
- POST, 4: entries captured after (not counting) the trigger entry; 0..DEPTH-1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- arm  in  1  one-cycle pulse: clear buffer, start capture
- abort  in  1  one-cycle pulse: stop capture, keep contents
- trig_pc  in  32  trigger address, sampled every cycle
- cap_valid  in  1  fetch-stage PC/instr valid this cycle
- cap_pc  in  32  fetch-stage PC
- cap_instr  in  32  fetch-stage instruction
- rd_ready  in  1  consumer accepts the head entry
- rd_valid  out  1  head entry available
- rd_pc  out  32  head entry PC
- rd_instr  out  32  head entry instruction
- count  out  $clog2(DEPTH)+1  entries held
- done  out  1  trigger seen and post-trigger capture complete
- overflow  out  1  sticky: at least one entry was overwritten since the last arm
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3

## Operation
- Circular buffer with wr_ptr, rd_ptr and count. Each entry is 64 bits: {pc, instr}.
- IDLE: no capture. Readout is allowed. arm → ARMED, with wr_ptr, rd_ptr, count and overflow cleared.
- ARMED: every cap_valid writes one entry. If the buffer is full, the oldest entry is overwritten: rd_ptr advances, count holds, and overflow is set.
  - Trigger condition: cap_valid && cap_pc == trig_pc. The trigger entry is written and the post counter is loaded with POST.
  - On trigger, go to POST, or directly to DONE when POST == 0.
- POST: every cap_valid writes one entry, with the same overwrite rule, and decrements the post counter.
  - The write that takes the post counter from 1 to 0 also moves the state to DONE.
  - A further trig_pc match in POST has no effect.
- DONE: no capture. Readout is allowed. done = 1.
- Readout:
  - rd_valid = (count ≠ 0) && state ∈ {IDLE, DONE}.
  - rd_pc and rd_instr present the entry at rd_ptr combinationally (show-ahead).
  - rd_valid && rd_ready pops one entry: rd_ptr + 1 modulo DEPTH, count − 1.
  - rd_ready with rd_valid = 0 is ignored.
- abort in ARMED or POST → IDLE. Contents, count and overflow are retained; done stays 0.
- Priority within one cycle: abort > arm > capture/trigger. arm in any state, including DONE or mid-readout, clears and re-arms.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.

## Timing
- Reset values: state = IDLE, count = 0, done = 0, overflow = 0, rd_valid = 0, pointers = 0.
  - rd_pc and rd_instr are don't-care while rd_valid = 0; the bench must not check them.
- Capture:
  - An entry is written on the edge where cap_valid = 1.
  - count and rd_valid reflect that write from the next cycle.
  - First capture is the cycle after the arm pulse. cap_valid in the same cycle as arm is not recorded.
- State is registered. DONE, and done = 1, are visible the cycle after the final post-trigger write. With POST = 0, that is the cycle after the trigger write.
- Readout throughput is one entry per cycle with rd_ready held at 1. The next head is visible the cycle after a pop.
- reset asserted mid-capture or mid-readout returns everything to the reset values asynchronously. Buffer RAM contents are not required to clear.

## Test plan
- Reset release, no arm; cap_valid = 1 for 10 cycles → count = 0, rd_valid = 0, state = IDLE.
- POST = 4, trig_pc = 0x20. Arm, then feed PCs 0x00, 0x04, …, 0x40, one per cycle → DONE one cycle after PC 0x30. Readout yields 0x00 … 0x30 (13 entries) in order; overflow = 0; rd_valid drops after the 13th pop.
- DEPTH = 16, POST = 4, trig_pc = 0x80. Feed PCs 0x00 … 0x90, 37 writes → overflow = 1, count = 16. Readout yields 0x54 … 0x90.
- POST = 0, trig_pc = 0x08 → done rises the cycle after the 0x08 write. Last entry read is 0x08.
- Arm, capture 5 entries (no trigger), abort → state = IDLE, count = 5, done = 0, all 5 readable. Then arm in the same cycle as a pop → count = 0, state = ARMED.
- Assert reset low during POST, with count = 9 → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - fetch-stream trace capture around a trigger PC
// Circular {pc, instr} buffer: overwrite-oldest while capturing, show-ahead drain when idle/done.
module pipe_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int POST  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [31:0]              trig_pc,
  input  logic                     cap_valid,
  input  logic [31:0]              cap_pc,
  input  logic [31:0]              cap_instr,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW-1:0] POST_C  = POST[AW-1:0];
  localparam logic [AW-1:0] ONE_C   = {{(AW-1){1'b0}}, 1'b1};

  logic [63:0]   mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          wr_en;
  logic          capturing;

  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
  assign rd_valid  = (count_q != '0) && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign rd_pc     = mem_q[rd_ptr_q][63:32];
  assign rd_instr  = mem_q[rd_ptr_q][31:0];
  assign count     = count_q;
  assign done      = (state_q == S_DONE);
  assign overflow  = overflow_q;
  assign state     = state_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    post_cnt_d = post_cnt_q;
    wr_en      = 1'b0;
    if (abort && capturing) begin
      state_d = S_IDLE;
    end else if (arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      post_cnt_d = '0;
    end else if (capturing && cap_valid) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      // A full buffer drops its oldest entry so the newest history is kept.
      if (count_q == DEPTH_C) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
      if (state_q == S_ARMED) begin
        if (cap_pc == trig_pc) begin
          post_cnt_d = POST_C;
          state_d    = (POST == 0) ? S_DONE : S_POST;
        end
      end else begin
        post_cnt_d = post_cnt_q - 1'b1;
        if (post_cnt_q == ONE_C) state_d = S_DONE;
      end
    end else if (rd_valid && rd_ready) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {cap_pc, cap_instr};
  end

endmodule
